// File: rtl/spimaster_pkg.sv
// Shared definitions for the SPI memory initiator: frame geometry, the R/W
// bit encoding, FSM state encodings and a helper that assembles the frame.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package spimaster_pkg;

   // Frame geometry: 7 address bits, 1 R/W bit, 8 data bits, MSB first.
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = ADDR_W + 1 + DATA_W;
   localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

   // Encoding of the R/W bit as it travels on the wire.
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_t;

   // Build the 16-bit outgoing frame. Reads send zeros in the data slot so
   // the responder never sees stale write data on a read.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [ADDR_W-1:0] addr,
      input logic              rw,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] data_slot;
      data_slot = (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}};
      return {addr, rw, data_slot};
   endfunction

endpackage

// File: rtl/spimaster_phase_timer.sv
// Phase timer: counts CLKDIV clk cycles per sclk half-period.
// Latency: phase_end/sample assert on the last cycle of each CLKDIV-cycle phase.
// Backpressure: none; clear holds the count at zero so a phase starts cleanly.
//
// Ports:
//   clk, reset_n  - system clock, async active-low reset
//   clear         - hold counter at zero (asserted while the master is idle)
//   phase_end     - one-cycle strobe on the last cycle of a phase
//   sample        - strobe on the same cycle, used to capture miso
module spimaster_phase_timer #(
   parameter int CLKDIV = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic phase_end,
   output logic sample
);

   localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKDIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             last_cycle;

   assign last_cycle = (cnt_q == LAST);

   // Every state change of the master happens on a phase end, and the count
   // wraps to zero on that same edge, so each new state starts at count 0.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || last_cycle) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign phase_end = last_cycle && !clear;
   assign sample    = last_cycle && !clear;

endmodule

// File: rtl/spimaster.sv
// SPI initiator for the lab SPI memory: one start strobe -> one 16-bit frame.
// Latency: busy/cs/first mosi bit on the accept edge; done (33+2*CS_GAP)*CLKDIV cycles later.
// Backpressure: start is only sampled while idle; requests during a frame are dropped.
//
// Ports:
//   clk, reset_n          - system clock (shared with spimemory), async active-low reset
//   start, rw, addr, wdata - request strobe and its operands, latched on accept
//   busy, done, rdata     - in-flight flag, completion pulse, last byte read
//   sclk, cs, mosi, miso  - SPI pins; sclk idles low, cs active low
module spimaster
   import spimaster_pkg::*;
#(
   parameter int CLKDIV = 16,
   parameter int CS_GAP = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              sclk,
   output logic              cs,
   output logic              mosi,
   input  logic              miso
);

   // The post-frame gap is 2*CS_GAP phases with sclk toggling and cs high.
   localparam int GAP_PHASES = 2 * CS_GAP;
   localparam int GAP_W      = (GAP_PHASES > 1) ? $clog2(GAP_PHASES) : 1;
   localparam logic [GAP_W-1:0]     GAP_LAST     = GAP_W'(GAP_PHASES - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);
   // Bits from this index onward are the data slot of the frame.
   localparam logic [BIT_CNT_W-1:0] FIRST_RX_BIT = BIT_CNT_W'(FRAME_BITS - DATA_W);

   state_t                 state_q,   state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic [FRAME_BITS-1:0]  tx_q,      tx_d;
   logic [DATA_W-1:0]      rx_q,      rx_d;
   logic                   rw_q,      rw_d;
   logic                   busy_q,    busy_d;
   logic                   done_q,    done_d;
   logic [DATA_W-1:0]      rdata_q,   rdata_d;
   logic                   sclk_q,    sclk_d;
   logic                   cs_q,      cs_d;
   logic                   mosi_q,    mosi_d;

   logic                   phase_end;
   logic                   sample;
   logic [FRAME_BITS-1:0]  frame_in;

   assign frame_in = build_frame(addr, rw, wdata);

   spimaster_phase_timer #(
      .CLKDIV (CLKDIV)
   ) u_phase_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (state_q == ST_IDLE),
      .phase_end (phase_end),
      .sample    (sample)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rw_d      = rw_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rdata_d   = rdata_q;
      sclk_d    = sclk_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Operands are latched here; later input changes are ignored.
               state_d   = ST_SETUP;
               tx_d      = frame_in;
               rw_d      = rw;
               rx_d      = '0;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               cs_d      = 1'b0;
               sclk_d    = 1'b0;
               mosi_d    = frame_in[FRAME_BITS-1];
            end
         end

         ST_SETUP: begin
            if (phase_end) begin
               state_d = ST_HIGH;
               sclk_d  = 1'b1;
            end
         end

         ST_HIGH: begin
            // miso is stable by the end of the high phase: the responder
            // updated it right after the preceding falling edge.
            if (sample && (bit_cnt_q >= FIRST_RX_BIT)) begin
               rx_d = {rx_q[DATA_W-2:0], miso};
            end
            if (phase_end) begin
               sclk_d = 1'b0;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_HOLD;
               end else begin
                  // mosi only moves on the falling edge, giving the responder
                  // a full half-period of setup before its rising-edge sample.
                  // The register rotates so bit 14 is always the next bit out.
                  state_d   = ST_LOW;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  tx_d      = {tx_q[FRAME_BITS-2:0], tx_q[FRAME_BITS-1]};
                  mosi_d    = tx_q[FRAME_BITS-2];
               end
            end
         end

         ST_LOW: begin
            if (phase_end) begin
               state_d = ST_HIGH;
               sclk_d  = 1'b1;
            end
         end

         ST_HOLD: begin
            if (phase_end) begin
               // sclk keeps toggling with cs high so the responder's FSM,
               // which is clocked by sclk, walks back to its idle state.
               state_d   = ST_GAP;
               cs_d      = 1'b1;
               mosi_d    = 1'b0;
               sclk_d    = 1'b1;
               gap_cnt_d = '0;
            end
         end

         ST_GAP: begin
            if (phase_end) begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d = ST_IDLE;
                  sclk_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  if (rw_q == RW_READ) begin
                     rdata_d = rx_q;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
                  sclk_d    = ~sclk_q;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rw_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rw_q      <= rw_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign sclk  = sclk_q;
   assign cs    = cs_q;
   assign mosi  = mosi_q;

endmodule

// File: tb/tb_spimaster.sv
// Bench for spimaster: behavioural SPI memory responder plus a scoreboard of
// expected frames and read bytes; a second instance runs with CLKDIV=4, CS_GAP=1.
`timescale 1ns/1ps
module tb_spimaster;

   localparam int BUSY_LEN  = 592;
   localparam int BUSY_LEN2 = 140;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Default instance
   logic       reset_n, start, rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       busy, done, sclk, cs, mosi;
   logic       miso = 1'b0;
   logic [7:0] rdata;

   spimaster #(.CLKDIV(16), .CS_GAP(2)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
      .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .sclk(sclk),
      .cs(cs), .mosi(mosi), .miso(miso)
   );

   // Fast instance
   logic       start2, rw2;
   logic [6:0] addr2;
   logic [7:0] wdata2;
   logic       busy2, done2, sclk2, cs2, mosi2;
   logic       miso2 = 1'b0;
   logic [7:0] rdata2;

   spimaster #(.CLKDIV(4), .CS_GAP(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .rw(rw2), .addr(addr2),
      .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2), .sclk(sclk2),
      .cs(cs2), .mosi(mosi2), .miso(miso2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural responder: samples mosi on sclk rises while cs is low,
   // drives miso after falls 8..15 of a read. Address 7'h12 is a fixed
   // pattern (8'hC3) that is never written.
   logic [7:0]  rsp_mem [128] = '{default: 8'h00};
   logic [15:0] rsp_sh = '0;
   int          rsp_cnt = 0;
   logic        rsp_prev = 1'b0;
   logic        rsp_cs_prev = 1'b1;
   logic        rsp_rd = 1'b0;
   logic [7:0]  rsp_out = '0;

   always @(negedge clk) begin
      if (rsp_cs_prev && !cs) begin
         rsp_cnt = 0;
         rsp_rd  = 1'b0;
      end
      if (!cs) begin
         if (sclk && !rsp_prev) begin
            rsp_sh = {rsp_sh[14:0], mosi};
            rsp_cnt++;
            if (rsp_cnt == 8 && rsp_sh[0]) begin
               rsp_rd  = 1'b1;
               rsp_out = (rsp_sh[7:1] == 7'h12) ? 8'hC3 : rsp_mem[rsp_sh[7:1]];
            end
            if (rsp_cnt == 16 && !rsp_sh[8]) rsp_mem[rsp_sh[15:9]] = rsp_sh[7:0];
         end
         if (!sclk && rsp_prev && rsp_rd && rsp_cnt >= 8 && rsp_cnt <= 15)
            miso = rsp_out[15 - rsp_cnt];
      end else begin
         miso = 1'b0;
      end
      rsp_prev    = sclk;
      rsp_cs_prev = cs;
   end

   int done_cnt = 0;
   always @(negedge clk) if (done) done_cnt++;

   // sclk rises seen on the fast instance, split by cs level.
   int   hi2 = 0, lo2 = 0;
   logic prev2 = 1'b0;
   always @(negedge clk) begin
      if (sclk2 && !prev2) begin
         if (cs2) hi2++;
         else lo2++;
      end
      prev2 = sclk2;
   end

   // Scoreboard and reference memory
   logic [15:0] exp_frame_q [$];
   logic [7:0]  exp_rdata_q [$];
   logic [7:0]  mem_ref [128];
   logic [7:0]  last_rd;

   task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d, input bit poke);
      int a_cyc, waited, dc0;
      logic [15:0] ef;
      logic [7:0]  er;
      exp_frame_q.push_back({a, r, r ? 8'h00 : d});
      if (r) exp_rdata_q.push_back(mem_ref[a]);
      else mem_ref[a] = d;
      dc0 = done_cnt;
      @(negedge clk);
      start = 1'b1; rw = r; addr = a; wdata = d;
      @(negedge clk);
      start = 1'b0; a_cyc = cyc;
      chk("busy_after_accept", busy, 1);
      chk("cs_after_accept", cs, 0);
      rw = ~r; addr = ~a; wdata = ~d;
      if (poke) begin
         repeat (100) @(negedge clk);
         start = 1'b1; rw = 1'b0; addr = 7'h7F; wdata = 8'hFF;
         @(negedge clk);
         start = 1'b0;
      end
      waited = 0;
      while (done !== 1'b1 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (done !== 1'b1) begin
         chk("done_timeout", 0, 1);
         exp_frame_q.delete();
         exp_rdata_q.delete();
      end else begin
         chk("busy_len", cyc - a_cyc, BUSY_LEN);
         chk("busy_at_done", busy, 0);
         ef = exp_frame_q.pop_front();
         chk("frame", rsp_sh, ef);
         chk("rise_cnt", rsp_cnt, 16);
         if (r) begin
            er = exp_rdata_q.pop_front();
            chk("rdata", rdata, er);
            last_rd = er;
         end else begin
            chk("rdata_hold", rdata, last_rd);
         end
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("done_count", done_cnt - dc0, 1);
      end
   endtask

   initial begin
      int waited, a_cyc, h0, l0;
      for (int i = 0; i < 128; i++) mem_ref[i] = 8'h00;
      mem_ref[7'h12] = 8'hC3;
      last_rd = 8'h00;
      reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", cs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 8'h00);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_txn(1'b0, 7'h00, 8'hAA, 1'b0);
      run_txn(1'b1, 7'h00, 8'h00, 1'b0);
      run_txn(1'b0, 7'h55, 8'h3C, 1'b0);
      chk("pin_frame_55_3c", rsp_sh, 16'hAA3C);
      run_txn(1'b1, 7'h12, 8'h00, 1'b1);
      run_txn(1'b1, 7'h55, 8'h00, 1'b0);

      // Reset during bit 5 of a read
      @(negedge clk);
      start = 1'b1; rw = 1'b1; addr = 7'h00;
      @(negedge clk);
      start = 1'b0;
      waited = 0;
      while (rsp_cnt != 5 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_bit5", rsp_cnt, 5);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cs", cs, 1);
      chk("mid_rst_sclk", sclk, 0);
      chk("mid_rst_mosi", mosi, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rdata", rdata, 8'h00);
      last_rd = 8'h00;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      run_txn(1'b1, 7'h00, 8'h00, 1'b0);

      // Fast instance: CLKDIV=4, CS_GAP=1
      h0 = hi2; l0 = lo2;
      @(negedge clk);
      start2 = 1'b1; rw2 = 1'b0; addr2 = 7'h2A; wdata2 = 8'h81;
      @(negedge clk);
      start2 = 1'b0; a_cyc = cyc;
      waited = 0;
      while (done2 !== 1'b1 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (done2 !== 1'b1) begin
         chk("done2_timeout", 0, 1);
      end else begin
         chk("busy_len2", cyc - a_cyc, BUSY_LEN2);
         chk("busy2_at_done", busy2, 0);
         chk("rdata2_hold", rdata2, 8'h00);
      end
      @(negedge clk);
      chk("gap_pulses2", hi2 - h0, 1);
      chk("frame_rises2", lo2 - l0, 16);
      chk("mosi2_idle", mosi2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
